// File: rtl/frame_activity_monitor.sv
// Turns completed stream frames into rate-limited one-cycle activity pulses and
// reports frame/drop counts plus a stall flag for the monitored handshake.
`timescale 1ns/1ps
module frame_activity_monitor #(
  parameter int unsigned FRAME_BEATS    = 4096,
  parameter int unsigned HOLDOFF_CYCLES = 1024,
  parameter int unsigned STALL_TIMEOUT  = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        in_ready,
  input  logic        clear,
  output logic        activity_trigger,
  output logic        frame_active,
  output logic [15:0] frame_count,
  output logic [7:0]  dropped_count,
  output logic        stall
);

  localparam int unsigned BeatW  = $clog2(FRAME_BEATS);
  localparam int unsigned HoldW  = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam int unsigned StallW = $clog2(STALL_TIMEOUT + 1);

  localparam logic [BeatW-1:0]  LastBeat   = BeatW'(FRAME_BEATS - 1);
  localparam logic [HoldW-1:0]  HoldReload = HoldW'(HOLDOFF_CYCLES - 1);
  localparam logic [StallW-1:0] StallMax   = StallW'(STALL_TIMEOUT);

  typedef enum logic [1:0] {StReady, StHoldoff, StPending} state_e;

  state_e              state_q, state_d;
  logic [BeatW-1:0]    beat_q, beat_d;
  logic [HoldW-1:0]    hold_q, hold_d;
  logic [StallW-1:0]   stall_cnt_q, stall_cnt_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [7:0]          drop_q, drop_d;
  logic                trig_q, trig_d;
  logic                active_q, active_d;
  logic                stall_q, stall_d;

  logic beat, frame_done, hold_expired;

  assign beat         = in_valid & in_ready;
  assign frame_done   = beat & (beat_q == LastBeat);
  // hold_q counts down so that a pending frame fires exactly HOLDOFF_CYCLES after the last pulse
  assign hold_expired = (hold_q == '0);

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_expired ? hold_q : hold_q - 1'b1;
    trig_d      = 1'b0;
    drop_d      = drop_q;
    frame_cnt_d = frame_cnt_q + {15'd0, frame_done};

    if (frame_done) begin
      beat_d = '0;
    end else if (beat) begin
      beat_d = beat_q + 1'b1;
    end else begin
      beat_d = beat_q;
    end

    unique case (state_q)
      StReady: begin
        if (frame_done) begin
          trig_d  = 1'b1;
          hold_d  = HoldReload;
          state_d = StHoldoff;
        end
      end
      StHoldoff: begin
        if (hold_expired) begin
          if (frame_done) begin
            trig_d = 1'b1;
            hold_d = HoldReload;
          end else begin
            state_d = StReady;
          end
        end else if (frame_done) begin
          state_d = StPending;
        end
      end
      StPending: begin
        // A frame landing on the release cycle is still coalesced away
        if (frame_done && drop_q != 8'hFF) begin
          drop_d = drop_q + 8'd1;
        end
        if (hold_expired) begin
          trig_d  = 1'b1;
          hold_d  = HoldReload;
          state_d = StHoldoff;
        end
      end
      default: state_d = StReady;
    endcase

    if (in_valid & ~in_ready) begin
      stall_cnt_d = (stall_cnt_q == StallMax) ? stall_cnt_q : stall_cnt_q + 1'b1;
    end else begin
      stall_cnt_d = '0;
    end
    stall_d  = (stall_cnt_d == StallMax);
    active_d = (beat_d != '0);

    if (clear) begin
      state_d     = StReady;
      beat_d      = '0;
      hold_d      = '0;
      trig_d      = 1'b0;
      drop_d      = '0;
      frame_cnt_d = '0;
      stall_cnt_d = '0;
      stall_d     = 1'b0;
      active_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StReady;
      beat_q      <= '0;
      hold_q      <= '0;
      trig_q      <= 1'b0;
      drop_q      <= '0;
      frame_cnt_q <= '0;
      stall_cnt_q <= '0;
      stall_q     <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      hold_q      <= hold_d;
      trig_q      <= trig_d;
      drop_q      <= drop_d;
      frame_cnt_q <= frame_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      stall_q     <= stall_d;
      active_q    <= active_d;
    end
  end

  assign activity_trigger = trig_q;
  assign frame_active     = active_q;
  assign frame_count      = frame_cnt_q;
  assign dropped_count    = drop_q;
  assign stall            = stall_q;

endmodule

// File: tb/tb_frame_activity_monitor.sv
// Scoreboard bench: expected trigger cycles are queued by the stimulus and
// popped by an independent monitor whenever activity_trigger is seen.
`timescale 1ns/1ps
module tb_frame_activity_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, clear;
  logic        activity_trigger, frame_active, stall;
  logic [15:0] frame_count;
  logic [7:0]  dropped_count;

  int cyc    = 0;
  int n_cmp  = 0;
  int n_fail = 0;
  int exp_q[$];
  int e_cyc;
  int b;

  frame_activity_monitor #(
    .FRAME_BEATS   (4),
    .HOLDOFF_CYCLES(8),
    .STALL_TIMEOUT (5)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .clear           (clear),
    .activity_trigger(activity_trigger),
    .frame_active    (frame_active),
    .frame_count     (frame_count),
    .dropped_count   (dropped_count),
    .stall           (stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Trigger monitor: every observed pulse must match the oldest expected cycle
  always @(negedge clk) begin
    if (activity_trigger) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL trigger: pulse at cycle %0d, expected none", cyc);
      end else begin
        e_cyc = exp_q.pop_front();
        if (e_cyc != cyc) begin
          n_fail++;
          $display("FAIL trigger: pulse at cycle %0d, expected at cycle %0d", cyc, e_cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  task automatic drive(input logic v, input logic r, input logic c);
    in_valid = v;
    in_ready = r;
    clear    = c;
    @(negedge clk);
  endtask

  task automatic idle_until(input int c);
    in_valid = 1'b0;
    in_ready = 1'b0;
    clear    = 1'b0;
    while (cyc < c) @(negedge clk);
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0);
    in_valid = 1'b0;
    in_ready = 1'b0;
  endtask

  // Clears the DUT, confirms the cleared state and returns the scenario base cycle
  task automatic start_scenario(output int base);
    drive(1'b0, 1'b0, 1'b1);
    clear = 1'b0;
    base  = cyc;
    check("clear_frame_count", int'(frame_count), 0);
    check("clear_dropped", int'(dropped_count), 0);
    check("clear_stall", int'(stall), 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_ready = 1'b0;
    clear    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_trigger", int'(activity_trigger), 0);
    check("reset_active", int'(frame_active), 0);
    check("reset_frame_count", int'(frame_count), 0);
    check("reset_dropped", int'(dropped_count), 0);
    check("reset_stall", int'(stall), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single frame: beats 10..13, trigger 14
    start_scenario(b);
    exp_q.push_back(b + 14);
    idle_until(b + 10);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      check("single_active", int'(frame_active), (i < 3) ? 1 : 0);
    end
    idle_until(b + 24);
    check("single_frame_count", int'(frame_count), 1);
    check("single_dropped", int'(dropped_count), 0);

    // Holdoff coalescing: beats 10..21, triggers 14 and 22, one dropped
    start_scenario(b);
    exp_q.push_back(b + 14);
    exp_q.push_back(b + 22);
    idle_until(b + 10);
    beats(12);
    idle_until(b + 34);
    check("coalesce_frame_count", int'(frame_count), 3);
    check("coalesce_dropped", int'(dropped_count), 1);

    // Pending release: frames done at 13 and 17, triggers 14 and 22
    start_scenario(b);
    exp_q.push_back(b + 14);
    exp_q.push_back(b + 22);
    idle_until(b + 10);
    beats(8);
    idle_until(b + 34);
    check("pending_frame_count", int'(frame_count), 2);
    check("pending_dropped", int'(dropped_count), 0);

    // Stall: valid without ready 30..36, ready in 37
    start_scenario(b);
    idle_until(b + 30);
    for (int c = 30; c <= 37; c++) begin
      drive(1'b1, (c == 37) ? 1'b1 : 1'b0, 1'b0);
      if (c + 1 == 34) check("stall_before", int'(stall), 0);
      if (c + 1 == 35) check("stall_rise", int'(stall), 1);
      if (c + 1 == 37) check("stall_held", int'(stall), 1);
      if (c + 1 == 38) check("stall_fall", int'(stall), 0);
    end
    idle_until(b + 50);
    check("stall_frame_count", int'(frame_count), 0);

    // Clear mid-frame: 2 beats, clear with a beat, then 4 beats -> trigger 17
    start_scenario(b);
    exp_q.push_back(b + 17);
    idle_until(b + 10);
    beats(2);
    check("clrmid_active_before", int'(frame_active), 1);
    drive(1'b1, 1'b1, 1'b1);
    clear = 1'b0;
    check("clrmid_active_after", int'(frame_active), 0);
    beats(4);
    idle_until(b + 30);
    check("clrmid_frame_count", int'(frame_count), 1);

    // Dropped saturation: 520 back-to-back frames, triggers every 8 cycles
    start_scenario(b);
    for (int k = 0; k <= 260; k++) exp_q.push_back(b + 14 + 8 * k);
    idle_until(b + 10);
    beats(2080);
    idle_until(b + 2110);
    check("sat_frame_count", int'(frame_count), 520);
    check("sat_dropped", int'(dropped_count), 255);

    // Async reset while PENDING with dropped_count 3 and a partial frame
    start_scenario(b);
    for (int k = 0; k < 4; k++) exp_q.push_back(b + 14 + 8 * k);
    idle_until(b + 10);
    beats(33);
    check("prereset_active", int'(frame_active), 1);
    check("prereset_frame_count", int'(frame_count), 8);
    check("prereset_dropped", int'(dropped_count), 3);
    #1 rst_n = 1'b0;
    #1;
    check("async_trigger", int'(activity_trigger), 0);
    check("async_active", int'(frame_active), 0);
    check("async_frame_count", int'(frame_count), 0);
    check("async_dropped", int'(dropped_count), 0);
    check("async_stall", int'(stall), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_until(b + 70);
    check("postreset_frame_count", int'(frame_count), 0);

    check("missing_triggers", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
